// File: rtl/seg7_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_capture
// Description : Receiving end of a multiplexed 4-digit 7-segment display bus.
//               Samples the scanned seg/an lines, decodes each lit digit back
//               into a hex nibble and reassembles the full 16-bit word.
//               Reports each completed word with a one-cycle valid pulse,
//               plus undecodable-pattern, multi-hot-anode and timeout errors.
// Ports       : clk          - system clock
//               rst          - asynchronous reset, active low
//               seg[6:0]     - segment lines, seg[0]=a .. seg[6]=g
//               an[3:0]      - digit enables, an[3] = most significant digit
//               value[15:0]  - last complete frame, nibble i from digit an[i]
//               blank[3:0]   - per-digit "all segments off" for last frame
//               digit_err[3:0] - per-digit undecodable pattern for last frame
//               frame_valid  - one-cycle pulse when value/blank/digit_err load
//               an_err       - one-cycle pulse on a settled multi-hot anode
//               timeout      - one-cycle pulse when no frame completes in time
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_capture #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter bit ACTIVE_LOW     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic [3:0]  blank,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        an_err,
  output logic        timeout
);

  // Idle level of the raw {an,seg} bus, loaded into the synchronizer on reset
  localparam logic [10:0] c_idle = ACTIVE_LOW ? 11'h7FF : 11'h000;
  localparam int          c_tw   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [10:0]     r_sync1;
  logic [10:0]     r_sync2;
  logic [7:0]      r_stab;
  logic [3:0]      r_mask;
  logic [c_tw-1:0] r_tcnt;
  logic [3:0]      r_nib [4];
  logic [3:0]      r_sblank;
  logic [3:0]      r_serr;

  logic [10:0]     w_lines;
  logic [3:0]      w_an;
  logic [6:0]      w_seg;
  logic            w_settled;
  logic            w_capture;
  logic            w_an_multi;
  logic            w_frame;
  logic            w_tout_hit;
  logic [5:0]      w_dec;

  // Returns {err, blank, nibble} for an active-high {g..a} pattern
  function automatic logic [5:0] f_decode(input logic [6:0] p);
    case (p)
      7'h3F:   f_decode = 6'h00;
      7'h06:   f_decode = 6'h01;
      7'h5B:   f_decode = 6'h02;
      7'h4F:   f_decode = 6'h03;
      7'h66:   f_decode = 6'h04;
      7'h6D:   f_decode = 6'h05;
      7'h7D:   f_decode = 6'h06;
      7'h07:   f_decode = 6'h07;
      7'h7F:   f_decode = 6'h08;
      7'h6F:   f_decode = 6'h09;
      7'h77:   f_decode = 6'h0A;
      7'h7C:   f_decode = 6'h0B;
      7'h39:   f_decode = 6'h0C;
      7'h5E:   f_decode = 6'h0D;
      7'h79:   f_decode = 6'h0E;
      7'h71:   f_decode = 6'h0F;
      7'h00:   f_decode = 6'b01_0000;
      default: f_decode = 6'b10_0000;
    endcase
  endfunction

  // Two-flop synchronizer on the whole bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= c_idle;
      r_sync2 <= c_idle;
    end else begin
      r_sync1 <= {an, seg};
      r_sync2 <= r_sync1;
    end
  end

  assign w_lines = ACTIVE_LOW ? ~r_sync2 : r_sync2;
  assign w_an    = w_lines[10:7];
  assign w_seg   = w_lines[6:0];

  // r_sync1 is the value r_sync2 takes next cycle, so comparing the two lets
  // the counter read 0 on the first cycle a new {an,seg} is visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stab <= 8'd0;
    end else if (r_sync1 != r_sync2) begin
      r_stab <= 8'd0;
    end else if (r_stab != 8'hFF) begin
      r_stab <= r_stab + 8'd1;
    end
  end

  // The counter passes through SETTLE_CYCLES-1 once per dwell, so each
  // dwell triggers at most one capture or anode error.
  assign w_settled  = (r_stab == 8'(SETTLE_CYCLES - 1));
  assign w_capture  = w_settled && $onehot(w_an);
  assign w_an_multi = w_settled && ($countones(w_an) > 1);
  assign w_dec      = f_decode(w_seg);

  assign w_frame    = (r_mask == 4'hF);
  // Timeout fires on the edge where the counter would reach TIMEOUT_CYCLES-1;
  // a completing frame takes priority.
  assign w_tout_hit = !w_frame && (r_tcnt == c_tw'(TIMEOUT_CYCLES - 2));

  for (genvar k = 0; k < 4; k++) begin : g_slot
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_nib[k]    <= 4'h0;
        r_sblank[k] <= 1'b0;
        r_serr[k]   <= 1'b0;
      end else if (w_capture && w_an[k]) begin
        r_nib[k]    <= w_dec[3:0];
        r_sblank[k] <= w_dec[4];
        r_serr[k]   <= w_dec[5];
      end
    end
  end

  // Mask and timeout counter; a capture coinciding with a frame completion
  // or timeout lands in the freshly cleared mask.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mask <= 4'h0;
      r_tcnt <= '0;
    end else begin
      if (w_frame || w_tout_hit) begin
        r_mask <= w_capture ? w_an : 4'h0;
        r_tcnt <= '0;
      end else begin
        if (w_capture) begin
          r_mask <= r_mask | w_an;
        end
        r_tcnt <= r_tcnt + c_tw'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value       <= 16'h0000;
      blank       <= 4'h0;
      digit_err   <= 4'h0;
      frame_valid <= 1'b0;
      an_err      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      frame_valid <= w_frame;
      an_err      <= w_an_multi;
      timeout     <= w_tout_hit;
      if (w_frame) begin
        value     <= {r_nib[3], r_nib[2], r_nib[1], r_nib[0]};
        blank     <= r_sblank;
        digit_err <= r_serr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_capture
// Description : Directed self-checking bench for seg7_scan_capture. A main
//               instance (long timeout) covers decoding, framing and errors;
//               a second instance with TIMEOUT_CYCLES=64 shares the inputs
//               and covers the scan timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;

  logic [15:0] value,  value2;
  logic [3:0]  blank,  blank2;
  logic [3:0]  digit_err, digit_err2;
  logic        frame_valid, frame_valid2;
  logic        an_err, an_err2;
  logic        timeout, timeout2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fv_cnt = 0, fv_last = 0, fv_prev = 0;
  int ae_cnt = 0;
  int fv2_cnt = 0;
  int base, aebase;

  seg7_scan_capture #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(1048576), .ACTIVE_LOW(1'b1)) u_dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an),
    .value(value), .blank(blank), .digit_err(digit_err),
    .frame_valid(frame_valid), .an_err(an_err), .timeout(timeout)
  );

  seg7_scan_capture #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64), .ACTIVE_LOW(1'b1)) u_dut_to (
    .clk(clk), .rst(rst), .seg(seg), .an(an),
    .value(value2), .blank(blank2), .digit_err(digit_err2),
    .frame_valid(frame_valid2), .an_err(an_err2), .timeout(timeout2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pulse monitors, sampled mid-cycle
  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt++;
      fv_prev = fv_last;
      fv_last = cyc;
    end
    if (an_err) ae_cnt++;
    if (frame_valid2) fv2_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    step(n);
  endtask

  // Scan digits 0..3 with the given active-low patterns, 8 cycles each
  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    dwell(4'hE, s0, 8);
    dwell(4'hD, s1, 8);
    dwell(4'hB, s2, 8);
    dwell(4'h7, s3, 8);
  endtask

  initial begin
    rst = 1'b0;
    an  = 4'hF;
    seg = 7'h7F;
    step(3);

    // Reset state
    chk("rst_value", {16'h0, value}, 32'h0);
    chk("rst_flags", {22'h0, blank, digit_err, frame_valid, an_err}, 32'h0);
    chk("rst_timeout", {31'h0, timeout}, 32'h0);

    // Timeout: digits 0..2 only, then idle; release lands just after an edge
    rst = 1'b1;
    dwell(4'hE, 7'h79, 8);   // digit 0 = 1
    dwell(4'hD, 7'h24, 8);   // digit 1 = 2
    dwell(4'hB, 7'h30, 8);   // digit 2 = 3
    dwell(4'hF, 7'h7F, 38);  // 62 cycles since release
    chk("to_before", {31'h0, timeout2}, 32'h0);
    step(1);
    chk("to_fire", {31'h0, timeout2}, 32'h1);
    step(1);
    chk("to_after", {31'h0, timeout2}, 32'h0);
    chk("to_no_frame", fv2_cnt, 0);
    chk("to_value", {16'h0, value2}, 32'h0);
    chk("main_no_frame", fv_cnt, 0);

    // Digit 3 completes the main frame; the timed-out instance lost its mask
    dwell(4'h7, 7'h40, 8);   // digit 3 = 0
    chk("main_frame_cnt", fv_cnt, 1);
    chk("main_frame_val", {16'h0, value}, 32'h0321);
    chk("to_mask_cleared", fv2_cnt, 0);

    // Normal frame 4567 with exact latency on the final digit
    dwell(4'hF, 7'h7F, 4);
    base = fv_cnt;
    dwell(4'hE, 7'h78, 8);
    dwell(4'hD, 7'h02, 8);
    dwell(4'hB, 7'h12, 8);
    an  = 4'h7;
    seg = 7'h19;
    step(6);
    chk("lat_early", {31'h0, frame_valid}, 32'h0);
    step(1);
    chk("lat_pulse", {31'h0, frame_valid}, 32'h1);
    chk("norm_value", {16'h0, value}, 32'h4567);
    chk("norm_flags", {24'h0, blank, digit_err}, 32'h0);
    step(1);
    chk("lat_one_cycle", {31'h0, frame_valid}, 32'h0);
    scan4(7'h78, 7'h02, 7'h12, 7'h19);
    scan4(7'h78, 7'h02, 7'h12, 7'h19);
    chk("repeat_cnt", fv_cnt, base + 3);
    chk("repeat_period", fv_last - fv_prev, 32);

    // Hex letters with a blank digit 0
    dwell(4'hF, 7'h7F, 4);
    scan4(7'h7F, 7'h46, 7'h03, 7'h08);
    chk("hex_value", {16'h0, value}, 32'hABC0);
    chk("hex_blank", {28'h0, blank}, 32'h1);
    chk("hex_err", {28'h0, digit_err}, 32'h0);

    // Short-dwell glitch on digit 0
    dwell(4'hF, 7'h7F, 4);
    base = fv_cnt;
    dwell(4'hE, 7'h79, 3);
    dwell(4'hD, 7'h24, 8);
    dwell(4'hB, 7'h30, 8);
    dwell(4'h7, 7'h19, 8);
    chk("glitch_no_frame", fv_cnt, base);
    dwell(4'hE, 7'h10, 8);   // digit 0 = 9
    chk("glitch_frame_cnt", fv_cnt, base + 1);
    chk("glitch_value", {16'h0, value}, 32'h4329);

    // Multi-hot anode and undecodable pattern
    dwell(4'hF, 7'h7F, 4);
    base   = fv_cnt;
    aebase = ae_cnt;
    dwell(4'hE, 7'h79, 8);
    dwell(4'hD, 7'h7E, 8);   // segment a only
    dwell(4'hB, 7'h24, 8);
    dwell(4'hC, 7'h7F, 8);   // digits 0 and 1 both enabled
    chk("an_err_cnt", ae_cnt, aebase + 1);
    chk("an_err_no_frame", fv_cnt, base);
    dwell(4'h7, 7'h30, 8);
    chk("err_frame_cnt", fv_cnt, base + 1);
    chk("err_value", {16'h0, value}, 32'h3201);
    chk("err_digit_err", {28'h0, digit_err}, 32'h2);
    chk("err_blank", {28'h0, blank}, 32'h0);

    // Reset mid-frame
    dwell(4'hF, 7'h7F, 4);
    dwell(4'hE, 7'h79, 8);
    dwell(4'hD, 7'h24, 8);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_value", {16'h0, value}, 32'h0);
    chk("async_rst_flags", {24'h0, blank, digit_err}, 32'h0);
    step(2);
    chk("held_rst_value", {16'h0, value}, 32'h0);
    rst  = 1'b1;
    base = fv_cnt;
    dwell(4'hB, 7'h24, 8);   // digit 2 = 2
    dwell(4'h7, 7'h79, 8);   // digit 3 = 1
    chk("rst_partial_discard", fv_cnt, base);
    dwell(4'hE, 7'h19, 8);   // digit 0 = 4
    dwell(4'hD, 7'h30, 8);   // digit 1 = 3
    chk("rst_frame_cnt", fv_cnt, base + 1);
    chk("rst_frame_value", {16'h0, value}, 32'h1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receiving end of the multiplexed 7-segment display interface driven by the FFT top (seg/an pins).
- Samples the scanned seg/an lines, decodes each lit digit back to a hex nibble and reassembles the full 4-digit word.
- Reports each completed word with a one-cycle valid pulse, plus pattern, anode and timeout errors.
- Used on-chip as a self-check monitor and in benches to read results numerically instead of from waveforms.

Parameters:
- SETTLE_CYCLES, 4: consecutive unchanged synchronized cycles required before a digit is captured; legal range 1..255.
- TIMEOUT_CYCLES, 1048576: cycles without a completed frame before timeout fires.
- ACTIVE_LOW, 1: 1 means seg and an are active-low, as driven by the FFT top; 0 means active-high.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-low reset.
- seg, in, 7: segment lines; seg[0]=a … seg[6]=g.
- an, in, 4: digit enables; an[3] is the most-significant digit.
- value, out, 16: last complete frame; nibble i comes from digit an[i].
- blank, out, 4: per-digit "all segments off" flag for the last frame.
- digit_err, out, 4: per-digit undecodable-pattern flag for the last frame.
- frame_valid, out, 1: one-cycle pulse when value, blank and digit_err update.
- an_err, out, 1: one-cycle pulse on a multi-hot anode dwell.
- timeout, out, 1: one-cycle pulse on scan timeout.

Behaviour:
- Reset (rst=0, asynchronous):
  - value=0, blank=0, digit_err=0, frame_valid=0, an_err=0, timeout=0.
  - Capture mask, stability counter and timeout counter are cleared.
  - Synchronizer flops load the inactive level: all ones when ACTIVE_LOW=1.
- Input handling:
  - seg and an pass through a 2-flop synchronizer, then are normalized to active-high internally per ACTIVE_LOW.
- Stability counter:
  - Resets to 0 whenever the synchronized {an,seg} differs from the previous cycle; otherwise increments, saturating.
  - A dwell is "settled" when the counter equals SETTLE_CYCLES−1.
- Capture, on the settled cycle only, so at most once per dwell:
  - One-hot an, digit k:
    - Decode seg to slot k and set mask[k].
    - A second dwell on the same k before frame completion overwrites slot k.
  - an all inactive: no action.
  - an with two or more bits active: an_err pulses and nothing is captured.
- Decode (active-high {g..a} pattern → nibble):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F.
  - Pattern 00: nibble 0, blank=1.
  - Any other pattern: nibble 0, digit_err=1.
- Frame completion:
  - The cycle after mask becomes 4'b1111, value/blank/digit_err load the slot contents and frame_valid pulses.
  - mask is cleared in the same cycle.
  - Outputs hold until the next frame.
  - Latency from the raw input change that starts the final digit's dwell to frame_valid: 2 + SETTLE_CYCLES + 1 cycles.
- Timeout:
  - Counter clears on frame_valid and increments otherwise.
  - On reaching TIMEOUT_CYCLES−1: timeout pulses, the counter clears and mask clears; value is retained.
- Simultaneous events:
  - Frame completion and timeout on the same cycle: frame wins, timeout is suppressed.
  - A capture in the frame-completion cycle goes into the fresh (cleared) mask.
- Reset mid-dwell or mid-frame discards partial slots; the first frame after reset needs all four digits again.

Test Plan (ACTIVE_LOW=1, SETTLE_CYCLES=4; each dwell 8 cycles unless noted):
- Normal frame: scan an=E,D,B,7 with seg=0x78,0x02,0x12,0x19 (digits 7,6,5,4) → one frame_valid pulse, value=16'h4567, blank=0, digit_err=0; repeating the scan gives a pulse every 32 cycles.
- Hex letters plus blank: digits 3..0 = A,b,C,blank (seg 0x08,0x03,0x46,0x7F) → value=16'hABC0, blank=4'b0001, digit_err=0.
- Short-dwell glitch: an=E for 3 cycles then switch → digit 0 not captured and no frame_valid; a subsequent full 8-cycle dwell captures it.
- Anode and pattern errors: an=4'b1100 settled → an_err pulses once, mask unchanged; seg=0x7E (segment a only) on digit 1 → frame completes with digit_err=4'b0010, nibble 1=0.
- Timeout: TIMEOUT_CYCLES=64, only digits 0..2 scanned → timeout pulses at cycle 63 after reset release, no frame_valid, value stays 0.
- Reset mid-frame: assert rst after digits 0,1 captured, release, then scan all four with value 0x1234 → exactly one frame_valid with value=16'h1234; outputs read 0 during reset regardless of clk.
